// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for arb_mux_n
package mux_pkg;

    localparam logic MODE_RR     = 1'b0;
    localparam logic MODE_MANUAL = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_mux_n_if.sv
// rtl/arb_mux_n_if.sv - request/response bundle between requesters, arb_mux_n and consumer
interface arb_mux_n_if #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SEL_W = mux_pkg::clog2(N)
);

    logic                 mode;
    logic [SEL_W-1:0]     selector;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SEL_W-1:0]     out_sel;

    modport master (
        output mode, selector, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sel
    );

    modport slave (
        input  mode, selector, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sel
    );

endinterface

// File: rtl/arb_mux_n_rr_pick.sv
// rtl/arb_mux_n_rr_pick.sv - combinational round-robin picker (rotate, priority-encode, un-rotate)
module rr_pick
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [N-1:0]     rot;
    logic [N-1:0]     rot_grant;
    logic [SEL_W-1:0] off;
    logic [SEL_W:0]   sum;

    always_comb begin
        // Doubling the vector turns the rotate into a plain shift; ptr is always < N.
        rot       = N'({req, req} >> ptr);
        rot_grant = '0;
        off       = '0;
        any       = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!any && rot[j]) begin
                any          = 1'b1;
                off          = SEL_W'(j);
                rot_grant[j] = 1'b1;
            end
        end

        grant = N'(({rot_grant, rot_grant} << ptr) >> N);

        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (SEL_W + 1)'(N)) begin
            sum = sum - (SEL_W + 1)'(N);
        end
        idx = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/arb_mux_n.sv
// rtl/arb_mux_n.sv - registered N-to-1 mux with manual select or round-robin arbitration
module arb_mux_n
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SEL_W = clog2(N)
) (
    input  logic     clk,
    input  logic     rst,
    arb_mux_n_if.slave bus
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] ptr_q;

    logic             is_manual;
    logic             load_en;
    logic             sel_ok;
    logic             has_grant;
    logic             xfer;
    logic [N-1:0]     man_grant;
    logic [N-1:0]     rr_grant;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] ptr_next;
    logic             rr_any;
    logic [WIDTH-1:0] grant_data;

    rr_pick #(.N(N)) u_rr_pick (
        .req   (bus.in_valid),
        .ptr   (ptr_q),
        .grant (rr_grant),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    always_comb begin
        is_manual = (bus.mode == MODE_MANUAL);
        load_en   = !valid_q || bus.out_ready;

        // Out-of-range selectors decode to no grant rather than indexing past in_valid.
        sel_ok    = (int'(bus.selector) < N);
        man_grant = sel_ok ? ((N'(1) << bus.selector) & bus.in_valid) : '0;

        if (is_manual) begin
            grant     = man_grant;
            grant_idx = bus.selector;
            has_grant = |man_grant;
        end else begin
            grant     = rr_grant;
            grant_idx = rr_idx;
            has_grant = rr_any;
        end

        xfer         = !rst && load_en && has_grant;
        bus.in_ready = xfer ? grant : '0;

        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end

        ptr_next = (int'(rr_idx) == N - 1) ? '0 : rr_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else if (xfer) begin
            data_q  <= grant_data;
            valid_q <= 1'b1;
            sel_q   <= grant_idx;
            if (!is_manual) begin
                ptr_q <= ptr_next;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_sel   = sel_q;

endmodule
